cache_bus_agent: RTL
====================

// Module: cache_bus_agent
// PURPOSE
//  Per-CPU snooping cache controller: the bus-side end of the 13-bit coherence message protocol
//  that the two-CPU bus arbiter routes. Serves local read/write requests from a small
//  direct-mapped MSI cache. Issues miss, invalidate and write-back messages on bus_out.
//  Snoops peer messages on bus_in, supplies dirty data and downgrades or invalidates lines.
// PARAMETERS
//  LINES   2   cache lines, power of 2; index = address[log2(LINES)-1:0], tag = remaining bits
//  ADDR_W  3   address width
//  DATA_W  4   data word width; MSG_W = 6+ADDR_W+DATA_W (13 at defaults)
// PORTS
//  clock                input   1      single clock, all state updates on posedge
//  reset                input   1      asynchronous, active-high; clears all state
//  execute_instruction  input   1      request strobe; an op starts on its sampled rising edge
//  instruction          input   1      0 = read, 1 = write
//  address              input   ADDR_W request address
//  data_in              input   DATA_W write data
//  data_out             output  DATA_W read result; holds value until next read completes
//  done                 output  1      one-cycle completion pulse
//  bus_in               input   MSG_W  message from arbiter (peer broadcast or fill); held, not cleared
//  bus_out              output  MSG_W  message to arbiter
// BEHAVIOUR
//  Message bits: [12] WB, [11] SUPPLY, [10] SNOOP, [9] FETCH, [8] WR_INTENT, [7] INV,
//   [6:4] ADDR, [3:0] DATA. A fill is bus_in[12:7]==6'b001000 (SNOOP bit only).
//  Reset: data_out=0, done=0, bus_out=0, all lines Invalid, FSM IDLE, wb_pending=0.
//   Reset mid-op abandons the op; no done pulse is issued.
//  bus_in_q register holds the previous bus_in. A bus message is "new" only when bus_in != bus_in_q.
//  FSM states: IDLE, LOOKUP, INV, WB, MISS, DONE, SWB.
//  IDLE -> LOOKUP when an execute_instruction rise is sampled. The request is latched at that edge.
//   A rise seen while busy is ignored. If wb_pending=1, IDLE -> SWB first, then the op starts.
//  LOOKUP: the outcome depends on access type and line state.
//   Read hit (S/M): data_out loaded -> DONE.
//   Write hit M: data written -> DONE.
//   Write hit S -> INV.
//   Miss, victim M -> WB.
//   Miss, victim not M -> MISS.
//  INV: bus_out={WB0,SUP0,SNOOP1,FETCH0,WR0,INV1,addr,data_in} for 1 cycle; line->M, data written -> DONE.
//  WB: bus_out={1,0,0,0,0,0,victim_addr,victim_data} for 1 cycle; victim->I -> MISS.
//  MISS: bus_out has SNOOP=1, FETCH=1, WR_INTENT=instruction, plus addr; held every cycle until a
//   new fill with ADDR==request addr. Fills for other addresses are ignored.
//   On the matching fill:
//    Read: line<-fill data, state S, data_out<-fill data.
//    Write: line<-data_in, state M.
//   bus_out drops to 0 at that same edge; -> DONE.
//  DONE: done=1 for exactly one cycle -> IDLE.
//  Latency from the sampled execute rise:
//   Read/write hit: done 2 cycles later.
//   Write hit on S: done 3 cycles later.
//   Miss: done 1 cycle after the fill edge.
//  Snoop: the peer message is new, SNOOP=1, not a fill, and its tag matches a valid line.
//   Read miss (FETCH=1, WR_INTENT=0) on M line:
//    bus_out={0,1,0,0,0,0,addr,line_data} combinationally in the same cycle.
//    Next edge: line M->S and wb_pending=1.
//   Write miss (FETCH=1, WR_INTENT=1) on M line: same SUPPLY response; next edge line->I, no write-back.
//   Write miss or INV on S line: line->I. Read miss on S line: no action.
//   A SUPPLY response overrides the own bus_out for that cycle only; own MISS/WB messages resume
//    after it. A one-cycle WB or INV that is overridden is re-issued in the next cycle.
//  SWB: bus_out={1,0,0,0,0,0,addr,data} for 1 cycle, clears wb_pending.
//  A snoop hitting the line of the own pending miss (MISS state) is applied first. The fill then
//   overwrites the line.
// STRUCTURE
//  Shared header bus_msg_defs.vh holds: message bit positions; FILL pattern 6'b001000;
//   MSI encodings I=2'b00, S=2'b01, M=2'b10; FSM state encodings.
//  Sub-module cache_line_store: LINES entries of {msi,tag,data}. It has a registered write port, a
//   combinational request lookup and a combinational snoop lookup port.
// TESTING
//  1 Reset; read 3'b101 -> FETCH msg addr 5; fill data 4'hA -> data_out=4'hA, done 1 cycle, line S.
//  2 Read 5 again -> no bus traffic, done 2 cycles after strobe, data_out=4'hA.
//  3 Write 4'h3 to 5 (line S) -> one INV msg addr 5 data 3, done, line M.
//  4 Peer read-miss addr 5 on bus_in -> same-cycle bus_out SUPPLY data 4'h3; next SWB msg; line S.
//  5 Line M at addr 1, write miss addr 3 (same index) -> WB msg addr 1, then FETCH+WR_INTENT addr 3;
//    fill -> line M data_in.
//  6 Assert reset during MISS -> bus_out=0, done=0 immediately; a later fill is ignored, lines Invalid.

Source files
------------

// File: rtl/cache_bus_agent_pkg.sv
// Shared definitions for the snooping cache agent: message header layout, MSI encodings
// and controller state encodings.
package cache_bus_agent_pkg;

  localparam int HDR_W     = 6;
  localparam int HDR_SNOOP = 3;
  localparam int HDR_FETCH = 2;
  localparam int HDR_WR    = 1;
  localparam int HDR_INV   = 0;

  localparam logic [HDR_W-1:0] FILL_HDR = 6'b001000;

  typedef enum logic [1:0] {
    MSI_I = 2'b00,
    MSI_S = 2'b01,
    MSI_M = 2'b10
  } msi_t;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOOKUP = 3'd1,
    ST_INV    = 3'd2,
    ST_WB     = 3'd3,
    ST_MISS   = 3'd4,
    ST_DONE   = 3'd5,
    ST_SWB    = 3'd6
  } state_t;

  // Header field order, MSB first: WB, SUPPLY, SNOOP, FETCH, WR_INTENT, INV.
  function automatic logic [HDR_W-1:0] msg_hdr(input logic wb, input logic sup,
                                               input logic snoop, input logic fetch,
                                               input logic wr, input logic inv);
    return {wb, sup, snoop, fetch, wr, inv};
  endfunction

endpackage

// File: rtl/cache_line_store.sv
// Direct-mapped line storage {msi, tag, data}: one registered write port and two
// combinational read ports (local request side and bus snoop side).
module cache_line_store
  import cache_bus_agent_pkg::*;
#(
  parameter  int LINES  = 2,
  parameter  int ADDR_W = 3,
  parameter  int DATA_W = 4,
  localparam int IDX_W  = $clog2(LINES),
  localparam int TAG_W  = ADDR_W - IDX_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [IDX_W-1:0]  wr_idx,
  input  msi_t              wr_msi,
  input  logic [TAG_W-1:0]  wr_tag,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [IDX_W-1:0]  rq_idx,
  output msi_t              rq_msi,
  output logic [TAG_W-1:0]  rq_tag,
  output logic [DATA_W-1:0] rq_data,
  input  logic [IDX_W-1:0]  sn_idx,
  output msi_t              sn_msi,
  output logic [TAG_W-1:0]  sn_tag,
  output logic [DATA_W-1:0] sn_data
);

  msi_t              msi_q  [LINES];
  logic [TAG_W-1:0]  tag_q  [LINES];
  logic [DATA_W-1:0] data_q [LINES];

  // Only the coherence state needs clearing; tag/data of an Invalid line are never used.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < LINES; i++) msi_q[i] <= MSI_I;
    end else if (wr_en) begin
      msi_q[wr_idx] <= wr_msi;
    end
  end

  always_ff @(posedge clock) begin
    if (wr_en) begin
      tag_q[wr_idx]  <= wr_tag;
      data_q[wr_idx] <= wr_data;
    end
  end

  assign rq_msi  = msi_q[rq_idx];
  assign rq_tag  = tag_q[rq_idx];
  assign rq_data = data_q[rq_idx];
  assign sn_msi  = msi_q[sn_idx];
  assign sn_tag  = tag_q[sn_idx];
  assign sn_data = data_q[sn_idx];

endmodule

// File: rtl/cache_bus_agent.sv
// Per-CPU snooping MSI cache controller: serves local read/write requests and answers
// peer coherence messages on the shared bus.
module cache_bus_agent
  import cache_bus_agent_pkg::*;
#(
  parameter  int LINES  = 2,
  parameter  int ADDR_W = 3,
  parameter  int DATA_W = 4,
  localparam int MSG_W  = HDR_W + ADDR_W + DATA_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              execute_instruction,
  input  logic              instruction,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out,
  output logic              done,
  input  logic [MSG_W-1:0]  bus_in,
  output logic [MSG_W-1:0]  bus_out
);

  localparam int IDX_W = $clog2(LINES);
  localparam int TAG_W = ADDR_W - IDX_W;

  state_t            state_q, state_d;
  logic              exec_q;
  logic [MSG_W-1:0]  bus_in_q;
  logic              req_wr_q, op_pending_q, wb_pending_q;
  logic [ADDR_W-1:0] req_addr_q, wb_addr_q;
  logic [DATA_W-1:0] req_data_q, wb_data_q;

  msi_t              rq_msi, sn_msi, fsm_msi, st_msi;
  logic [TAG_W-1:0]  rq_tag, sn_tag, st_tag;
  logic [DATA_W-1:0] rq_data, sn_data, fsm_data, st_data, out_val;
  logic [IDX_W-1:0]  st_idx;
  logic              fsm_wr, st_wr, load_out;
  logic [MSG_W-1:0]  own_msg;

  logic [HDR_W-1:0]  in_hdr;
  logic [ADDR_W-1:0] in_addr;
  logic [DATA_W-1:0] in_data;
  logic              exec_rise, msg_new, is_fill, fill_hit, req_hit;
  logic              snoop_hit, supply, snoop_inv, snoop_down, snoop_wr;

  assign in_hdr  = bus_in[MSG_W-1 -: HDR_W];
  assign in_addr = bus_in[DATA_W +: ADDR_W];
  assign in_data = bus_in[DATA_W-1:0];

  assign exec_rise = execute_instruction & ~exec_q;
  assign msg_new   = (bus_in != bus_in_q);
  assign is_fill   = msg_new && (in_hdr == FILL_HDR);
  assign fill_hit  = is_fill && (in_addr == req_addr_q);
  assign req_hit   = (rq_msi != MSI_I) && (rq_tag == req_addr_q[ADDR_W-1:IDX_W]);

  // Peer snoop decode: only fresh, non-fill SNOOP messages that hit a valid line matter.
  assign snoop_hit  = msg_new && in_hdr[HDR_SNOOP] && !is_fill && (sn_msi != MSI_I) &&
                      (sn_tag == in_addr[ADDR_W-1:IDX_W]);
  assign supply     = snoop_hit && (sn_msi == MSI_M) && in_hdr[HDR_FETCH];
  assign snoop_down = supply && !in_hdr[HDR_WR];
  assign snoop_inv  = snoop_hit && ((sn_msi == MSI_M && in_hdr[HDR_FETCH] && in_hdr[HDR_WR]) ||
                      (sn_msi == MSI_S && ((in_hdr[HDR_FETCH] && in_hdr[HDR_WR]) || in_hdr[HDR_INV])));
  assign snoop_wr   = snoop_inv || snoop_down;

  // Snoop updates own the single write port; any state that writes the store (or whose
  // message is overridden by a SUPPLY) holds for a cycle and retries.
  assign st_wr   = snoop_wr || fsm_wr;
  assign st_idx  = snoop_wr ? in_addr[IDX_W-1:0] : req_addr_q[IDX_W-1:0];
  assign st_msi  = snoop_wr ? (snoop_inv ? MSI_I : MSI_S) : fsm_msi;
  assign st_tag  = snoop_wr ? sn_tag : req_addr_q[ADDR_W-1:IDX_W];
  assign st_data = snoop_wr ? sn_data : fsm_data;

  cache_line_store #(.LINES(LINES), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_store (
    .clock   (clock),
    .reset   (reset),
    .wr_en   (st_wr),
    .wr_idx  (st_idx),
    .wr_msi  (st_msi),
    .wr_tag  (st_tag),
    .wr_data (st_data),
    .rq_idx  (req_addr_q[IDX_W-1:0]),
    .rq_msi  (rq_msi),
    .rq_tag  (rq_tag),
    .rq_data (rq_data),
    .sn_idx  (in_addr[IDX_W-1:0]),
    .sn_msi  (sn_msi),
    .sn_tag  (sn_tag),
    .sn_data (sn_data)
  );

  always_comb begin
    state_d  = state_q;
    own_msg  = '0;
    fsm_wr   = 1'b0;
    fsm_msi  = MSI_I;
    fsm_data = req_data_q;
    load_out = 1'b0;
    out_val  = rq_data;
    case (state_q)
      ST_IDLE: begin
        if (wb_pending_q)   state_d = ST_SWB;
        else if (exec_rise) state_d = ST_LOOKUP;
      end
      ST_SWB: begin
        own_msg = {msg_hdr(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), wb_addr_q, wb_data_q};
        if (!supply) state_d = op_pending_q ? ST_LOOKUP : ST_IDLE;
      end
      ST_LOOKUP: begin
        if (!snoop_wr) begin
          if (req_hit && !req_wr_q) begin
            load_out = 1'b1;
            state_d  = ST_DONE;
          end else if (req_hit && rq_msi == MSI_M) begin
            fsm_wr  = 1'b1;
            fsm_msi = MSI_M;
            state_d = ST_DONE;
          end else if (req_hit) begin
            state_d = ST_INV;
          end else begin
            state_d = (rq_msi == MSI_M) ? ST_WB : ST_MISS;
          end
        end
      end
      ST_INV: begin
        own_msg = {msg_hdr(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1), req_addr_q, req_data_q};
        if (!snoop_wr) begin
          fsm_wr  = 1'b1;
          fsm_msi = MSI_M;
          state_d = ST_DONE;
        end
      end
      ST_WB: begin
        own_msg = {msg_hdr(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0),
                   rq_tag, req_addr_q[IDX_W-1:0], rq_data};
        if (!snoop_wr) begin
          fsm_wr   = 1'b1;
          fsm_msi  = MSI_I;
          fsm_data = rq_data;
          state_d  = ST_MISS;
        end
      end
      ST_MISS: begin
        own_msg = {msg_hdr(1'b0, 1'b0, 1'b1, 1'b1, req_wr_q, 1'b0), req_addr_q, {DATA_W{1'b0}}};
        if (fill_hit) begin
          fsm_wr   = 1'b1;
          fsm_msi  = req_wr_q ? MSI_M : MSI_S;
          fsm_data = req_wr_q ? req_data_q : in_data;
          load_out = !req_wr_q;
          out_val  = in_data;
          state_d  = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  assign bus_out = supply ? {msg_hdr(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0), in_addr, sn_data}
                          : own_msg;
  assign done    = (state_q == ST_DONE);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      exec_q       <= 1'b0;
      bus_in_q     <= '0;
      req_wr_q     <= 1'b0;
      req_addr_q   <= '0;
      req_data_q   <= '0;
      op_pending_q <= 1'b0;
      wb_pending_q <= 1'b0;
      wb_addr_q    <= '0;
      wb_data_q    <= '0;
      data_out     <= '0;
    end else begin
      state_q  <= state_d;
      exec_q   <= execute_instruction;
      bus_in_q <= bus_in;
      if (state_q == ST_IDLE && exec_rise) begin
        req_wr_q     <= instruction;
        req_addr_q   <= address;
        req_data_q   <= data_in;
        op_pending_q <= wb_pending_q;
      end
      if (state_q == ST_SWB && !supply) begin
        wb_pending_q <= 1'b0;
        op_pending_q <= 1'b0;
      end
      if (snoop_down) begin
        wb_pending_q <= 1'b1;
        wb_addr_q    <= in_addr;
        wb_data_q    <= sn_data;
      end
      if (load_out) data_out <= out_val;
    end
  end

endmodule
